// File: rtl/watch_set_ctrl.sv
// ---------------------------------------------------------------------------
// WatchSetCtrl (top: watch_set_ctrl)
//
// Time-setting sequencer for the watch datapath. While set mode is requested
// it snapshots the live watch time into shadow registers. The user then
// picks a field (hour/min/sec) and steps it up or down with modular wrap.
// Leaving set mode issues a one-cycle load of the edited time into the watch
// counters. A cancel pulse discards the edit instead. The block also drives
// a blink enable for the selected field's display digits.
//
// Ports
//   clk          system clock
//   reset        synchronous, active-high reset
//   i_set_watch  level, 1 = user requests set mode
//   i_cancel     one-cycle pulse, abandon edit without loading
//   i_btn_left   one-cycle pulse, move selection toward HOUR
//   i_btn_right  one-cycle pulse, move selection toward SEC
//   i_btn_up     one-cycle pulse, increment selected field
//   i_btn_down   one-cycle pulse, decrement selected field
//   i_hour       live watch hour   (0-23)
//   i_min        live watch minute (0-59)
//   i_sec        live watch second (0-59)
//   o_editing    1 while editing; datapath shows the shadow values
//   o_field      selected field: 0=SEC, 1=MIN, 2=HOUR
//   o_blink_on   1 = show selected field digits, 0 = blank them
//   o_load       one-cycle strobe: watch counters load o_hour/o_min/o_sec
//   o_hour       shadow hour
//   o_min        shadow minute
//   o_sec        shadow second
// ---------------------------------------------------------------------------
module watch_set_ctrl #(
  parameter int BLINK_HALF = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_set_watch,
  input  logic       i_cancel,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic [4:0] i_hour,
  input  logic [5:0] i_min,
  input  logic [5:0] i_sec,
  output logic       o_editing,
  output logic [1:0] o_field,
  output logic       o_blink_on,
  output logic       o_load,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec
);

  // A blink half-period of one cycle still needs a one-bit counter.
  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_HALF - 1);

  localparam logic [1:0] FIELD_SEC  = 2'd0;
  localparam logic [1:0] FIELD_MIN  = 2'd1;
  localparam logic [1:0] FIELD_HOUR = 2'd2;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MS_MAX   = 6'd59;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EDIT,
    COMMIT
  } state_t;

  state_t        state_q, state_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [1:0]    field_q, field_d;
  logic          editing_q, editing_d;
  logic          load_q, load_d;
  logic          blinkOn_q, blinkOn_d;
  logic [CW-1:0] blinkCnt_q, blinkCnt_d;

  logic          upOnly;
  logic          downOnly;
  logic          leftOnly;
  logic          rightOnly;
  logic          btnAccepted;

  // Increment with wrap. Using >= means a captured out-of-range value also
  // wraps to zero on the next up press.
  function automatic logic [5:0] stepUp(input logic [5:0] v, input logic [5:0] maxV);
    return (v >= maxV) ? 6'd0 : v + 6'd1;
  endfunction

  // Decrement with wrap. Out-of-range values simply count down.
  function automatic logic [5:0] stepDown(input logic [5:0] v, input logic [5:0] maxV);
    return (v == 6'd0) ? maxV : v - 6'd1;
  endfunction

  // Opposing buttons pressed in the same cycle cancel each other out. Only a
  // lone press counts as accepted. An accepted press also restarts the blink
  // phase.
  always_comb begin
    upOnly      = i_btn_up & ~i_btn_down;
    downOnly    = i_btn_down & ~i_btn_up;
    leftOnly    = i_btn_left & ~i_btn_right;
    rightOnly   = i_btn_right & ~i_btn_left;
    btnAccepted = upOnly | downOnly | leftOnly | rightOnly;
  end

  // Next-state and next-output logic. All outputs are registered, so each
  // state computes the value the outputs take on in the following state.
  always_comb begin
    state_d    = state_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    field_d    = field_q;
    editing_d  = 1'b0;
    load_d     = 1'b0;
    blinkOn_d  = 1'b1;
    blinkCnt_d = '0;

    unique case (state_q)
      IDLE: begin
        if (i_set_watch) begin
          state_d = CAPTURE;
        end
      end

      CAPTURE: begin
        hour_d    = i_hour;
        min_d     = i_min;
        sec_d     = i_sec;
        field_d   = FIELD_HOUR;
        editing_d = 1'b1;
        state_d   = EDIT;
      end

      EDIT: begin
        if (i_cancel) begin
          state_d = IDLE;
        end else if (!i_set_watch) begin
          // Buttons arriving on the exit cycle are dropped, so the load
          // carries exactly what the user saw.
          state_d = COMMIT;
          load_d  = 1'b1;
        end else begin
          editing_d = 1'b1;

          // The value change uses the field selected before any move in
          // this same cycle.
          if (upOnly) begin
            unique case (field_q)
              FIELD_HOUR: hour_d = 5'(stepUp({1'b0, hour_q}, HOUR_MAX));
              FIELD_MIN:  min_d  = stepUp(min_q, MS_MAX);
              FIELD_SEC:  sec_d  = stepUp(sec_q, MS_MAX);
              default:    ;
            endcase
          end else if (downOnly) begin
            unique case (field_q)
              FIELD_HOUR: hour_d = 5'(stepDown({1'b0, hour_q}, HOUR_MAX));
              FIELD_MIN:  min_d  = stepDown(min_q, MS_MAX);
              FIELD_SEC:  sec_d  = stepDown(sec_q, MS_MAX);
              default:    ;
            endcase
          end

          // Selection is circular: left wraps HOUR->SEC, right wraps SEC->HOUR.
          if (leftOnly) begin
            field_d = (field_q >= FIELD_HOUR) ? FIELD_SEC : field_q + 2'd1;
          end else if (rightOnly) begin
            field_d = (field_q == FIELD_SEC) ? FIELD_HOUR : field_q - 2'd1;
          end

          // Blink runs only while editing. A press shows the digits at once
          // and restarts the half-period.
          if (btnAccepted) begin
            blinkOn_d  = 1'b1;
            blinkCnt_d = '0;
          end else if (blinkCnt_q == BLINK_LAST) begin
            blinkOn_d  = ~blinkOn_q;
            blinkCnt_d = '0;
          end else begin
            blinkOn_d  = blinkOn_q;
            blinkCnt_d = blinkCnt_q + 1'b1;
          end
        end
      end

      COMMIT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers. Reset wins over everything, so a reset
  // arriving mid-edit never lets a load through.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      field_q    <= FIELD_HOUR;
      editing_q  <= 1'b0;
      load_q     <= 1'b0;
      blinkOn_q  <= 1'b1;
      blinkCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      field_q    <= field_d;
      editing_q  <= editing_d;
      load_q     <= load_d;
      blinkOn_q  <= blinkOn_d;
      blinkCnt_q <= blinkCnt_d;
    end
  end

  assign o_editing  = editing_q;
  assign o_field    = field_q;
  assign o_blink_on = blinkOn_q;
  assign o_load     = load_q;
  assign o_hour     = hour_q;
  assign o_min      = min_q;
  assign o_sec      = sec_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for watch_set_ctrl. Uses directed vectors with hand-computed
// expected values. The blink half-period is shortened to 4 cycles.
// ---------------------------------------------------------------------------
module tb_watch_set_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       iSetWatch;
  logic       iCancel;
  logic       iBtnLeft;
  logic       iBtnRight;
  logic       iBtnUp;
  logic       iBtnDown;
  logic [4:0] iHour;
  logic [5:0] iMin;
  logic [5:0] iSec;
  logic       oEditing;
  logic [1:0] oField;
  logic       oBlinkOn;
  logic       oLoad;
  logic [4:0] oHour;
  logic [5:0] oMin;
  logic [5:0] oSec;

  int checkCount = 0;
  int errorCount = 0;

  watch_set_ctrl #(.BLINK_HALF(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_set_watch (iSetWatch),
    .i_cancel    (iCancel),
    .i_btn_left  (iBtnLeft),
    .i_btn_right (iBtnRight),
    .i_btn_up    (iBtnUp),
    .i_btn_down  (iBtnDown),
    .i_hour      (iHour),
    .i_min       (iMin),
    .i_sec       (iSec),
    .o_editing   (oEditing),
    .o_field     (oField),
    .o_blink_on  (oBlinkOn),
    .o_load      (oLoad),
    .o_hour      (oHour),
    .o_min       (oMin),
    .o_sec       (oSec)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, pass the active edge, then drop the pulses.
  task automatic applyStimulus(input logic setWatch, input logic cancel,
                               input logic left, input logic right,
                               input logic up, input logic down);
    iSetWatch = setWatch;
    iCancel   = cancel;
    iBtnLeft  = left;
    iBtnRight = right;
    iBtnUp    = up;
    iBtnDown  = down;
    @(posedge clk);
    #1;
    iCancel   = 1'b0;
    iBtnLeft  = 1'b0;
    iBtnRight = 1'b0;
    iBtnUp    = 1'b0;
    iBtnDown  = 1'b0;
  endtask

  task automatic stepCycle(input logic setWatch);
    applyStimulus(setWatch, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    iSetWatch = 1'b0; iCancel = 1'b0;
    iBtnLeft = 1'b0; iBtnRight = 1'b0; iBtnUp = 1'b0; iBtnDown = 1'b0;
    iHour = 5'd0; iMin = 6'd0; iSec = 6'd0;
    #1;
    stepCycle(1'b0);
    stepCycle(1'b0);
    reset = 1'b0;

    // Reset state
    checkOutput("rst_editing", oEditing, 0);
    checkOutput("rst_load",    oLoad,    0);
    checkOutput("rst_field",   oField,   2);
    checkOutput("rst_blink",   oBlinkOn, 1);
    checkOutput("rst_hour",    oHour,    0);
    checkOutput("rst_min",     oMin,     0);
    checkOutput("rst_sec",     oSec,     0);

    // Capture / commit of 13:45:07
    iHour = 5'd13; iMin = 6'd45; iSec = 6'd7;
    stepCycle(1'b1);
    checkOutput("cap_editing_c1", oEditing, 0);
    stepCycle(1'b1);
    checkOutput("cap_editing_c2", oEditing, 1);
    checkOutput("cap_hour",  oHour,  13);
    checkOutput("cap_min",   oMin,   45);
    checkOutput("cap_sec",   oSec,   7);
    checkOutput("cap_field", oField, 2);
    checkOutput("cap_blink", oBlinkOn, 1);
    for (int i = 0; i < 8; i++) begin
      stepCycle(1'b1);
      checkOutput("cap_hold_load", oLoad, 0);
      checkOutput("cap_hold_editing", oEditing, 1);
    end
    stepCycle(1'b0);
    checkOutput("commit_load",    oLoad,    1);
    checkOutput("commit_editing", oEditing, 0);
    checkOutput("commit_hour",    oHour,    13);
    checkOutput("commit_min",     oMin,     45);
    checkOutput("commit_sec",     oSec,     7);
    stepCycle(1'b0);
    checkOutput("commit_load_drop", oLoad, 0);
    iHour = 5'd5;
    stepCycle(1'b0);
    checkOutput("idle_shadow_hold", oHour, 13);
    iHour = 5'd13;

    // Hour wrap: 13 -> 23 -> 0, then down -> 23
    stepCycle(1'b1);
    stepCycle(1'b1);
    for (int i = 1; i <= 11; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 10) checkOutput("hour_up_to_23", oHour, 23);
    end
    checkOutput("hour_wrap_0", oHour, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("hour_down_23", oHour, 23);
    stepCycle(1'b0);
    checkOutput("hwrap_load", oLoad, 1);
    checkOutput("hwrap_hour", oHour, 23);
    checkOutput("hwrap_min",  oMin,  45);
    checkOutput("hwrap_sec",  oSec,  7);
    stepCycle(1'b0);

    // Field select wrap and simultaneous buttons
    iSec = 6'd0;
    stepCycle(1'b1);
    stepCycle(1'b1);
    checkOutput("sel_start", oField, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("sel_left_wrap", oField, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("sec_down_wrap", oSec, 59);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("sel_right_wrap", oField, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("sel_left_right", oField, 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("val_up_down", oHour, 13);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("up_right_hour",  oHour,  14);
    checkOutput("up_right_field", oField, 1);
    checkOutput("up_right_min",   oMin,   45);
    stepCycle(1'b0);
    checkOutput("sel_load", oLoad, 1);
    checkOutput("sel_load_hour", oHour, 14);
    checkOutput("sel_load_sec",  oSec,  59);
    stepCycle(1'b0);

    // Cancel: three ups on MIN, then abandon
    iSec = 6'd7;
    stepCycle(1'b1);
    stepCycle(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("cancel_field_min", oField, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("cancel_min_48", oMin, 48);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("cancel_editing", oEditing, 0);
    checkOutput("cancel_load", oLoad, 0);
    for (int i = 0; i < 3; i++) begin
      stepCycle(1'b0);
      checkOutput("cancel_no_load", oLoad, 0);
    end
    checkOutput("cancel_min_kept", oMin, 48);

    // Blink with a 4-cycle half-period
    stepCycle(1'b1);
    stepCycle(1'b1);
    checkOutput("blink_entry", oBlinkOn, 1);
    for (int i = 0; i < 3; i++) stepCycle(1'b1);
    checkOutput("blink_still_on", oBlinkOn, 1);
    stepCycle(1'b1);
    checkOutput("blink_off", oBlinkOn, 0);
    stepCycle(1'b1);
    stepCycle(1'b1);
    checkOutput("blink_off_mid", oBlinkOn, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("blink_forced_on", oBlinkOn, 1);
    for (int i = 0; i < 3; i++) stepCycle(1'b1);
    checkOutput("blink_restart_on", oBlinkOn, 1);
    stepCycle(1'b1);
    checkOutput("blink_restart_off", oBlinkOn, 0);

    // Reset in the middle of an edit
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pre_reset_hour", oHour, 16);
    reset = 1'b1;
    stepCycle(1'b1);
    reset = 1'b0;
    checkOutput("mid_rst_editing", oEditing, 0);
    checkOutput("mid_rst_load",    oLoad,    0);
    checkOutput("mid_rst_field",   oField,   2);
    checkOutput("mid_rst_blink",   oBlinkOn, 1);
    checkOutput("mid_rst_hour",    oHour,    0);
    checkOutput("mid_rst_min",     oMin,     0);
    checkOutput("mid_rst_sec",     oSec,     0);
    for (int i = 0; i < 2; i++) begin
      stepCycle(1'b0);
      checkOutput("mid_rst_no_load", oLoad, 0);
    end

    // Exit on the same cycle as buttons: buttons ignored
    stepCycle(1'b1);
    stepCycle(1'b1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("exit_pre_hour", oHour, 14);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checkOutput("exit_btn_load",  oLoad,  1);
    checkOutput("exit_btn_hour",  oHour,  14);
    checkOutput("exit_btn_field", oField, 2);
    stepCycle(1'b0);

    // Out-of-range capture, cancel with set still high re-enters capture
    iHour = 5'd30;
    stepCycle(1'b1);
    stepCycle(1'b1);
    checkOutput("oor_capture", oHour, 30);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("oor_down", oHour, 29);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reenter_idle", oEditing, 0);
    stepCycle(1'b1);
    checkOutput("reenter_capture", oEditing, 0);
    stepCycle(1'b1);
    checkOutput("reenter_edit", oEditing, 1);
    checkOutput("reenter_hour", oHour, 30);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("oor_up_wrap", oHour, 0);
    stepCycle(1'b0);
    checkOutput("oor_load", oLoad, 1);
    checkOutput("oor_load_hour", oHour, 0);
    stepCycle(1'b0);
    checkOutput("oor_load_drop", oLoad, 0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
